// File: rtl/vga_draw_arbiter_pkg.sv
// Shared game definitions for the VGA draw arbiter:
// requester slots, screen geometry and arbiter states.
package vga_draw_arbiter_pkg;

  localparam int REQ_CLEAR  = 0;
  localparam int REQ_ROCKET = 1;
  localparam int REQ_ALIEN  = 2;
  localparam int REQ_BULLET = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int CNT_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arbState_t;

  function automatic logic [3:0] oneHot4(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_rr_pick3.sv
// Round-robin picker over the three game-object requesters.
// Search starts at last+1 and wraps from bullets back to rocket.
module rr_pick3
  import vga_draw_arbiter_pkg::*;
(
  input  logic [3:1] req,
  input  logic [1:0] last,
  output logic [3:1] pick
);

  always_comb begin
    pick = '0;
    unique case (last)
      2'd1: begin
        if (req[REQ_ALIEN])
          pick[REQ_ALIEN] = 1'b1;
        else if (req[REQ_BULLET])
          pick[REQ_BULLET] = 1'b1;
        else if (req[REQ_ROCKET])
          pick[REQ_ROCKET] = 1'b1;
      end
      2'd2: begin
        if (req[REQ_BULLET])
          pick[REQ_BULLET] = 1'b1;
        else if (req[REQ_ROCKET])
          pick[REQ_ROCKET] = 1'b1;
        else if (req[REQ_ALIEN])
          pick[REQ_ALIEN] = 1'b1;
      end
      default: begin
        if (req[REQ_ROCKET])
          pick[REQ_ROCKET] = 1'b1;
        else if (req[REQ_ALIEN])
          pick[REQ_ALIEN] = 1'b1;
        else if (req[REQ_BULLET])
          pick[REQ_BULLET] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Grants the single VGA write port to one draw requester at a time,
// clear first, game objects round-robin, with a one-cycle gap between.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAX_BURST = 19200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       done,
  input  logic [X_W*NREQ-1:0]   x_in,
  input  logic [Y_W*NREQ-1:0]   y_in,
  input  logic [C_W*NREQ-1:0]   c_in,
  input  logic [NREQ-1:0]       plot_in,
  output logic [NREQ-1:0]       gnt,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [C_W-1:0]        colour_out,
  output logic                  plot_out,
  output logic                  busy,
  output logic [CNT_W-1:0]      pix_count,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_BURST);

  arbState_t state, stateNxt;

  logic [1:0] gIdx, gIdxNxt;
  logic [1:0] lastServed, lastNxt;
  logic [1:0] newIdx;
  logic [3:1] rrPick;

  logic [NREQ-1:0]  gntNxt;
  logic [X_W-1:0]   xNxt;
  logic [Y_W-1:0]   yNxt;
  logic [C_W-1:0]   cNxt;
  logic             plotNxt;
  logic [CNT_W-1:0] cntNxt;
  logic             toNxt;

  logic             gPlot;
  logic             gDone;
  logic             gReq;
  logic [CNT_W-1:0] cntInc;
  logic             hitMax;
  logic             endBurst;

  rr_pick3 uPick (
    .req  (req[3:1]),
    .last (lastServed),
    .pick (rrPick)
  );

  // Clear wins outright; otherwise take the round-robin choice.
  always_comb begin
    newIdx = 2'(REQ_CLEAR);
    if (req[REQ_CLEAR])
      newIdx = 2'(REQ_CLEAR);
    else if (rrPick[REQ_ROCKET])
      newIdx = 2'(REQ_ROCKET);
    else if (rrPick[REQ_ALIEN])
      newIdx = 2'(REQ_ALIEN);
    else if (rrPick[REQ_BULLET])
      newIdx = 2'(REQ_BULLET);
  end

  assign gPlot = plot_in[gIdx];
  assign gDone = done[gIdx];
  assign gReq  = req[gIdx];

  assign cntInc = (pix_count == MAX_CNT) ?
    pix_count : pix_count + CNT_W'(gPlot);
  assign hitMax   = (cntInc == MAX_CNT);
  assign endBurst = gDone | ~gReq | hitMax;

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (|req) stateNxt = BUSY;
      BUSY:    if (endBurst) stateNxt = GAP;
      GAP:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // The pixel sampled on the releasing edge still reaches the port.
  always_comb begin
    gntNxt  = gnt;
    gIdxNxt = gIdx;
    lastNxt = lastServed;
    xNxt    = x_out;
    yNxt    = y_out;
    cNxt    = colour_out;
    cntNxt  = pix_count;
    plotNxt = 1'b0;
    toNxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gntNxt  = oneHot4(newIdx);
          gIdxNxt = newIdx;
          cntNxt  = '0;
          if (newIdx != 2'(REQ_CLEAR))
            lastNxt = newIdx;
        end
      end
      BUSY: begin
        xNxt    = x_in[X_W*gIdx +: X_W];
        yNxt    = y_in[Y_W*gIdx +: Y_W];
        cNxt    = c_in[C_W*gIdx +: C_W];
        plotNxt = gPlot;
        cntNxt  = cntInc;
        if (endBurst) begin
          gntNxt = '0;
          toNxt  = hitMax;
        end
      end
      GAP:     gntNxt = '0;
      default: gntNxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt        <= '0;
      gIdx       <= '0;
      lastServed <= 2'(REQ_BULLET);
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot_out   <= 1'b0;
      pix_count  <= '0;
      timeout    <= 1'b0;
    end else begin
      gnt        <= gntNxt;
      gIdx       <= gIdxNxt;
      lastServed <= lastNxt;
      x_out      <= xNxt;
      y_out      <= yNxt;
      colour_out <= cNxt;
      plot_out   <= plotNxt;
      pix_count  <= cntNxt;
      timeout    <= toNxt;
    end
  end

  assign busy = (state == BUSY);

endmodule
